// File: rtl/apb_ucpd_partner_tx.sv
// USB-PD BMC packet transmitter: preamble, ordered set, 4b5b payload, CRC-32, EOP.
// One-byte holding register feeds the payload; starvation aborts the packet.
module apb_ucpd_partner_tx #(
  parameter int PRE_BITS = 64
) (
  input  logic       ic_clk,
  input  logic       ic_rst_n,
  input  logic [5:0] hbitclkdiv,
  input  logic       start,
  input  logic [1:0] sop_type,
  input  logic [9:0] byte_cnt,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       cc_out,
  output logic       cc_oen,
  output logic       busy,
  output logic       done,
  output logic       underrun
);
  typedef enum logic [2:0] {IDLE, PRE, SOP, DATA, CRC, EOP, TAIL} state_t;

  localparam int PW = $clog2(PRE_BITS) + 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRE_BITS - 1);
  localparam logic [4:0] K_EOP = 5'h0D;

  function automatic logic [4:0] enc4b5b(input logic [3:0] n);
    logic [4:0] s;
    case (n)
      4'h0: s = 5'h1E;  4'h1: s = 5'h09;  4'h2: s = 5'h14;  4'h3: s = 5'h15;
      4'h4: s = 5'h0A;  4'h5: s = 5'h0B;  4'h6: s = 5'h0E;  4'h7: s = 5'h0F;
      4'h8: s = 5'h12;  4'h9: s = 5'h13;  4'hA: s = 5'h16;  4'hB: s = 5'h17;
      4'hC: s = 5'h1A;  4'hD: s = 5'h1B;  4'hE: s = 5'h1C;  default: s = 5'h1D;
    endcase
    return s;
  endfunction

  // Ordered-set symbol i (0..3) for each SOP type
  function automatic logic [4:0] sop_sym(input logic [1:0] t, input logic [1:0] i);
    logic [4:0] s;
    case (t)
      2'd0: s = (i == 2'd3) ? 5'h11 : 5'h18;
      2'd1: s = (i < 2'd2) ? 5'h18 : 5'h06;
      2'd2: s = i[0] ? 5'h06 : 5'h18;
      default: s = (i == 2'd3) ? 5'h19 : 5'h07;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  state_t        state_reg;
  logic [5:0]    div_reg, hb_cnt_reg;
  logic          half_reg;
  logic [PW-1:0] pre_cnt_reg;
  logic [2:0]    bit_cnt_reg, sym_idx_reg;
  logic [4:0]    sym_reg;
  logic [1:0]    type_reg;
  logic [9:0]    send_left_reg, fetch_left_reg;
  logic [7:0]    hold_reg, cur_byte_reg;
  logic          hold_full_reg, under_reg;
  logic [31:0]   crc_reg;
  logic          tx_ready_reg, cc_out_reg, cc_oen_reg, busy_reg, done_reg, underrun_reg;

  logic [31:0] crc_out;
  logic [2:0]  nidx;
  logic        hb_end, bit_end, sym_last, cur_bit, need_byte, starve, unload, accept;
  logic        hold_full_next, fetch_state, tx_ready_next;
  logic [9:0]  fetch_left_next;

  always_comb begin
    crc_out   = ~crc_reg;
    nidx      = sym_idx_reg + 3'd1;
    hb_end    = (hb_cnt_reg == 6'd0);
    bit_end   = (state_reg != IDLE) && hb_end && half_reg;
    sym_last  = (bit_cnt_reg == 3'd4);
    cur_bit   = (state_reg == PRE) ? pre_cnt_reg[0] : sym_reg[0];
    // A payload byte is due when the last bit of SOP or of a high nibble ends
    need_byte = bit_end && sym_last && (send_left_reg != 10'd0) &&
                ((state_reg == SOP && sym_idx_reg == 3'd3 && type_reg != 2'd3) ||
                 (state_reg == DATA && sym_idx_reg == 3'd1));
    starve    = need_byte && !hold_full_reg;
    unload    = need_byte && hold_full_reg;
    accept    = tx_valid && tx_ready_reg;
    hold_full_next  = accept || (hold_full_reg && !unload);
    fetch_left_next = fetch_left_reg - {9'd0, accept};
    fetch_state     = (state_reg == PRE) || (state_reg == SOP) || (state_reg == DATA);
    if (state_reg == IDLE)
      tx_ready_next = start && (sop_type != 2'd3) && (byte_cnt != 10'd0);
    else
      tx_ready_next = fetch_state && (type_reg != 2'd3) && !starve && !hold_full_next &&
                      (fetch_left_next != 10'd0);
  end

  always_ff @(posedge ic_clk) begin
    if (!ic_rst_n) begin
      state_reg      <= IDLE;
      div_reg        <= 6'd0;
      hb_cnt_reg     <= 6'd0;
      half_reg       <= 1'b0;
      pre_cnt_reg    <= '0;
      bit_cnt_reg    <= 3'd0;
      sym_idx_reg    <= 3'd0;
      sym_reg        <= 5'd0;
      type_reg       <= 2'd0;
      send_left_reg  <= 10'd0;
      fetch_left_reg <= 10'd0;
      hold_reg       <= 8'd0;
      cur_byte_reg   <= 8'd0;
      hold_full_reg  <= 1'b0;
      under_reg      <= 1'b0;
      crc_reg        <= 32'hFFFFFFFF;
      tx_ready_reg   <= 1'b0;
      cc_out_reg     <= 1'b0;
      cc_oen_reg     <= 1'b1;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      underrun_reg   <= 1'b0;
    end else begin
      done_reg       <= 1'b0;
      underrun_reg   <= 1'b0;
      tx_ready_reg   <= tx_ready_next;
      hold_full_reg  <= hold_full_next;
      fetch_left_reg <= fetch_left_next;
      if (accept) begin
        hold_reg <= tx_data;
        crc_reg  <= crc_byte(crc_reg, tx_data);
      end
      if (state_reg != IDLE) begin
        hb_cnt_reg <= hb_end ? div_reg : hb_cnt_reg - 6'd1;
        if (hb_end) half_reg <= ~half_reg;
      end

      case (state_reg)
        IDLE: begin
          div_reg <= hbitclkdiv;
          if (start) begin
            state_reg      <= PRE;
            type_reg       <= sop_type;
            send_left_reg  <= byte_cnt;
            fetch_left_reg <= byte_cnt;
            crc_reg        <= 32'hFFFFFFFF;
            hold_full_reg  <= 1'b0;
            under_reg      <= 1'b0;
            pre_cnt_reg    <= '0;
            hb_cnt_reg     <= hbitclkdiv;
            half_reg       <= 1'b0;
            cc_out_reg     <= 1'b1;
            cc_oen_reg     <= 1'b0;
            busy_reg       <= 1'b1;
          end
        end
        TAIL: begin
          if (bit_end) begin
            state_reg    <= IDLE;
            cc_oen_reg   <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= !under_reg;
            underrun_reg <= under_reg;
          end
        end
        default: begin
          if (hb_end && !half_reg) begin
            if (cur_bit) cc_out_reg <= ~cc_out_reg;
          end else if (bit_end) begin
            // Every bit starts with a transition; TAIL entry overrides to 0 below
            cc_out_reg <= ~cc_out_reg;
            if (state_reg == PRE) begin
              if (pre_cnt_reg == PRE_LAST) begin
                state_reg   <= SOP;
                sym_reg     <= sop_sym(type_reg, 2'd0);
                bit_cnt_reg <= 3'd0;
                sym_idx_reg <= 3'd0;
              end else begin
                pre_cnt_reg <= pre_cnt_reg + 1'b1;
              end
            end else if (!sym_last) begin
              sym_reg     <= sym_reg >> 1;
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end else begin
              bit_cnt_reg <= 3'd0;
              if (state_reg == SOP && sym_idx_reg != 3'd3) begin
                sym_reg     <= sop_sym(type_reg, nidx[1:0]);
                sym_idx_reg <= nidx;
              end else if (state_reg == DATA && sym_idx_reg == 3'd0) begin
                sym_reg     <= enc4b5b(cur_byte_reg[7:4]);
                sym_idx_reg <= 3'd1;
              end else if (state_reg == CRC && sym_idx_reg != 3'd7) begin
                sym_reg     <= enc4b5b(crc_out[{nidx, 2'b00} +: 4]);
                sym_idx_reg <= nidx;
              end else if (state_reg == CRC) begin
                state_reg <= EOP;
                sym_reg   <= K_EOP;
              end else if (state_reg == EOP || type_reg == 2'd3) begin
                state_reg  <= TAIL;
                cc_out_reg <= 1'b0;
              end else if (send_left_reg == 10'd0) begin
                state_reg   <= CRC;
                sym_reg     <= enc4b5b(crc_out[3:0]);
                sym_idx_reg <= 3'd0;
              end else if (hold_full_reg) begin
                state_reg     <= DATA;
                sym_reg       <= enc4b5b(hold_reg[3:0]);
                cur_byte_reg  <= hold_reg;
                send_left_reg <= send_left_reg - 10'd1;
                sym_idx_reg   <= 3'd0;
              end else begin
                state_reg  <= TAIL;
                cc_out_reg <= 1'b0;
                under_reg  <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  assign tx_ready = tx_ready_reg;
  assign cc_out   = cc_out_reg;
  assign cc_oen   = cc_oen_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign underrun = underrun_reg;

endmodule

// File: tb/tb_apb_ucpd_partner_tx.sv
// Scoreboard bench for apb_ucpd_partner_tx: a bit-level packet model is turned into the
// expected BMC line waveform, which a monitor compares sample by sample at packet end.
`timescale 1ns/1ps
module tb_apb_ucpd_partner_tx;
  localparam int PRE_BITS = 64;
  localparam logic [4:0] ENC [16] = '{5'h1E, 5'h09, 5'h14, 5'h15, 5'h0A, 5'h0B, 5'h0E, 5'h0F,
                                      5'h12, 5'h13, 5'h16, 5'h17, 5'h1A, 5'h1B, 5'h1C, 5'h1D};
  localparam logic [4:0] SOPT [4][4] = '{'{5'h18, 5'h18, 5'h18, 5'h11},
                                         '{5'h18, 5'h18, 5'h06, 5'h06},
                                         '{5'h18, 5'h06, 5'h18, 5'h06},
                                         '{5'h07, 5'h07, 5'h07, 5'h19}};
  localparam logic [4:0] K_EOP = 5'h0D;

  logic       ic_clk = 1'b0, ic_rst_n = 1'b0, start = 1'b0, tx_valid = 1'b0;
  logic [5:0] hbitclkdiv = 6'd0;
  logic [1:0] sop_type = 2'd0;
  logic [9:0] byte_cnt = 10'd0;
  logic [7:0] tx_data = 8'd0;
  logic       tx_ready, cc_out, cc_oen, busy, done, underrun;

  apb_ucpd_partner_tx #(.PRE_BITS(PRE_BITS)) dut (
    .ic_clk(ic_clk), .ic_rst_n(ic_rst_n), .hbitclkdiv(hbitclkdiv), .start(start),
    .sop_type(sop_type), .byte_cnt(byte_cnt), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .cc_out(cc_out), .cc_oen(cc_oen), .busy(busy), .done(done),
    .underrun(underrun)
  );

  always #5 ic_clk = ~ic_clk;

  int cyc = 0;
  always @(posedge ic_clk) cyc <= cyc + 1;

  int   n_cmp = 0, n_bad = 0, busy_err = 0;
  bit   mon_en = 0, abort = 0, saw_ready = 0;
  int   exp_kind_q[$], exp_cyc_q[$], exp_len_q[$];
  bit   exp_lvl_q[$], cap_q[$], mbits[$];
  logic [7:0] pkt_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // MSB-first CRC-32 over LSB-first data bits, reflected and inverted at the end
  function automatic logic [31:0] model_crc(input int n);
    logic [31:0] c, r;
    logic fb;
    c = 32'hFFFFFFFF;
    for (int j = 0; j < n; j++)
      for (int b = 0; b < 8; b++) begin
        fb = c[31] ^ pkt_q[j][b];
        c = c << 1;
        if (fb) c = c ^ 32'h04C11DB7;
      end
    for (int i = 0; i < 32; i++) r[i] = c[31-i];
    return ~r;
  endfunction

  task automatic push_sym(input logic [4:0] s);
    for (int i = 0; i < 5; i++) mbits.push_back(s[i]);
  endtask

  task automatic build_expect(input int div, input int typ, input int n, input int nsent,
                              input bit full, input int s, output int len);
    logic [31:0] crc;
    bit lvl;
    mbits.delete();
    for (int i = 0; i < PRE_BITS; i++) mbits.push_back(i % 2 == 1);
    for (int k = 0; k < 4; k++) push_sym(SOPT[typ][k]);
    for (int j = 0; j < nsent; j++) begin
      push_sym(ENC[pkt_q[j][3:0]]);
      push_sym(ENC[pkt_q[j][7:4]]);
    end
    if (full && typ != 3) begin
      crc = model_crc(n);
      for (int k = 0; k < 8; k++) push_sym(ENC[crc[4*k +: 4]]);
      push_sym(K_EOP);
    end
    lvl = 1'b0;
    foreach (mbits[i]) begin
      lvl = ~lvl;
      repeat (div + 1) exp_lvl_q.push_back(lvl);
      if (mbits[i]) lvl = ~lvl;
      repeat (div + 1) exp_lvl_q.push_back(lvl);
    end
    repeat (2 * (div + 1)) exp_lvl_q.push_back(1'b0);
    len = (2 * mbits.size() + 2) * (div + 1);
    exp_kind_q.push_back(full ? 2 : 1);
    exp_cyc_q.push_back(s + 1 + len);
    exp_len_q.push_back(len);
  endtask

  task automatic check_end();
    int ek, ec, el, mism, got_v, exp_v;
    bit lv;
    if (exp_kind_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL unexpected_end: packet end at cycle %0d, expected none pending", cyc);
      return;
    end
    ek = exp_kind_q.pop_front();
    ec = exp_cyc_q.pop_front();
    el = exp_len_q.pop_front();
    chk("end_kind", {done, underrun}, ek);
    chk("end_cycle", cyc, ec);
    chk("line_len", cap_q.size(), el);
    mism = -1; got_v = 0; exp_v = 0;
    for (int i = 0; i < el; i++) begin
      lv = exp_lvl_q.pop_front();
      if (i < cap_q.size() && cap_q[i] !== lv && mism < 0) begin
        mism = i; got_v = cap_q[i]; exp_v = lv;
      end
    end
    n_cmp++;
    if (mism >= 0) begin
      n_bad++;
      $display("FAIL line_wave: sample %0d got %0d, expected %0d", mism, got_v, exp_v);
    end
    chk("busy_vs_oen", busy_err, 0);
    busy_err = 0;
    $display("[tb] packet end cycle %0d: %s, %0d driven cycles", cyc,
             done ? "done" : "underrun", cap_q.size());
  endtask

  always @(negedge ic_clk) begin
    if (mon_en) begin
      if (busy === cc_oen) busy_err++;
      if (cc_oen) begin
        if (done || underrun) check_end();
        cap_q.delete();
      end else begin
        cap_q.push_back(cc_out);
        if (done || underrun) begin
          n_cmp++; n_bad++;
          $display("FAIL end_while_driving: end pulse at cycle %0d, expected line released", cyc);
        end
      end
    end
  end

  task automatic feed(input int nfeed);
    int gap, t;
    for (int j = 0; j < nfeed && !abort; j++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge ic_clk);
      tx_valid = 1'b1;
      tx_data  = pkt_q[j];
      t = 0;
      while (!tx_ready && !abort && t < 4000) begin
        @(negedge ic_clk);
        t++;
      end
      if (abort) break;
      if (t >= 4000) begin
        n_cmp++; n_bad++;
        $display("FAIL feed_timeout: byte %0d never accepted, expected tx_ready", j);
        break;
      end
      @(negedge ic_clk);
    end
    tx_valid = 1'b0;
  endtask

  task automatic waiter(input int len, input bit rep_start, input int reset_at, input int div_alt);
    int k, ek, el;
    k = 0;
    while (exp_kind_q.size() != 0 && k < len + 100 && !abort) begin
      start = rep_start && (k == len / 2);
      if (start) hbitclkdiv = 6'(div_alt);
      if (tx_ready) saw_ready = 1'b1;
      if (reset_at > 0 && k == reset_at) begin
        ic_rst_n = 1'b0;
        @(negedge ic_clk);
        ic_rst_n = 1'b1;
        abort = 1'b1;
        chk("rst_cc_oen", cc_oen, 1);
        chk("rst_busy", busy, 0);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_cc_out", cc_out, 0);
        ek = exp_kind_q.pop_back();
        ek = exp_cyc_q.pop_back();
        el = exp_len_q.pop_back();
        repeat (el) void'(exp_lvl_q.pop_back());
      end else begin
        @(negedge ic_clk);
        k++;
      end
    end
    start = 1'b0;
    if (!abort && exp_kind_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL end_timeout: no end pulse within %0d cycles, expected one", len + 100);
      exp_kind_q.delete(); exp_cyc_q.delete(); exp_len_q.delete(); exp_lvl_q.delete();
    end
  endtask

  task automatic run_packet(input int div, input int typ, input int n, input int stall_k,
                            input bit fixed_data, input bit rep_start, input int reset_at,
                            input int div_alt);
    int s, len, nfeed;
    bit full;
    if (!fixed_data) begin
      pkt_q.delete();
      for (int j = 0; j < n; j++) pkt_q.push_back(8'($urandom));
    end
    full  = !(stall_k >= 0 && stall_k < n && typ != 3);
    nfeed = (typ == 3) ? 0 : (full ? n : stall_k);
    hbitclkdiv = 6'(div);
    sop_type   = 2'(typ);
    byte_cnt   = 10'(n);
    s = cyc;
    build_expect(div, typ, n, nfeed, full, s, len);
    start = 1'b1;
    @(negedge ic_clk);
    start = 1'b0;
    abort = 1'b0;
    saw_ready = 1'b0;
    fork
      feed(nfeed);
      waiter(len, rep_start, reset_at, div_alt);
    join
    if (typ == 3) chk("hr_tx_ready_seen", saw_ready, 0);
    if (rep_start) begin
      repeat (30) @(negedge ic_clk);
      chk("no_second_packet_busy", busy, 0);
    end
    repeat (3) @(negedge ic_clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int typ, n, div, stall;
    repeat (3) @(negedge ic_clk);
    chk("reset_cc_oen", cc_oen, 1);
    chk("reset_cc_out", cc_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_tx_ready", tx_ready, 0);
    chk("reset_done", done, 0);
    chk("reset_underrun", underrun, 0);
    ic_rst_n = 1'b1;
    mon_en   = 1'b1;
    @(negedge ic_clk);

    run_packet(0, 0, 0, -1, 0, 0, 0, 0);                // empty payload, fastest clock
    run_packet(0, 3, 5, -1, 0, 0, 0, 0);                // hard reset ignores payload
    pkt_q.delete(); pkt_q.push_back(8'hA5); pkt_q.push_back(8'h3C);
    run_packet(1, 1, 2, -1, 1, 0, 0, 0);                // SOP' with A5 3C
    run_packet(0, 0, 3, 1, 0, 0, 0, 0);                 // starve after first byte
    run_packet(0, 2, 4, -1, 0, 0, 190, 0);              // reset in DATA
    run_packet(0, 2, 4, -1, 0, 0, 0, 0);                // clean packet after reset
    run_packet(5, 0, 2, -1, 0, 1, 0, 2);                // repeated start, divider change
    for (int i = 0; i < 8; i++) begin
      typ   = $urandom_range(0, 3);
      n     = $urandom_range(0, 6);
      div   = $urandom_range(0, 3);
      stall = (n > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
      run_packet(div, typ, n, stall, 0, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
